// File: rtl/gf2_pkg.sv
// Shared definitions for the GF(2) polynomial divider and related blocks.
// Latency: n/a (types, default widths and a width helper only).
// Backpressure: n/a.
package gf2_pkg;

    localparam int GF2_DIVIDEND_W = 286;
    localparam int GF2_DIVISOR_W  = 143;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DEGREE = 2'd1,
        DIV    = 2'd2,
        DONE   = 2'd3
    } div_state_e;

    // Smallest counter width w such that 2^w > n.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) <= n) w++;
        return w;
    endfunction

endpackage

// File: rtl/gf2_lead_one_enc.sv
// Priority encoder: index of the most significant set bit, plus an all-zero flag.
// Latency: combinational.
// Backpressure: none (pure function of the input vector).
module gf2_lead_one_enc #(
    parameter int W     = 143,
    parameter int IDX_W = $clog2(W)
) (
    input  logic [W-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             zero
);

    // Scan upward so the highest set bit is the last one to write idx.
    always_comb begin
        idx  = '0;
        zero = (vec == '0);
        for (int i = 0; i < W; i++) begin
            if (vec[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/gf2_poly_div143.sv
// GF(2) polynomial long divider: d = q*b ^ r, deg(r) < deg(b), one dividend bit per cycle MSB first.
// Latency: out_valid DIVIDEND_W+1 edges after the accepting edge; 1 edge for a zero divisor.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
module gf2_poly_div143
    import gf2_pkg::*;
#(
    parameter int DIVIDEND_W = GF2_DIVIDEND_W,
    parameter int DIVISOR_W  = GF2_DIVISOR_W,
    parameter int CNT_W      = cnt_width(DIVIDEND_W)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int DEG_W = $clog2(DIVISOR_W);

    div_state_e state, state_nxt;

    logic [DIVIDEND_W-1:0] d_q;
    logic [DIVIDEND_W-1:0] q_q;
    logic [DIVISOR_W-1:0]  b_q;
    logic [DIVISOR_W-1:0]  r_q;
    logic [DEG_W-1:0]      deg_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  dbz_q;

    logic [DEG_W-1:0]      enc_idx;
    logic                  enc_zero;
    logic [DIVISOR_W-1:0]  t;
    logic                  qb;

    gf2_lead_one_enc #(
        .W     (DIVISOR_W),
        .IDX_W (DEG_W)
    ) u_deg_enc (
        .vec  (b_q),
        .idx  (enc_idx),
        .zero (enc_zero)
    );

    // Shift the next dividend bit into the partial remainder; bit deg decides the quotient bit.
    // deg(R) < deg keeps the top bit of R clear, so nothing is lost by the shift.
    assign t  = {r_q[DIVISOR_W-2:0], d_q[DIVIDEND_W-1]};
    assign qb = t[deg_q];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)      state_nxt = DEGREE;
            DEGREE:  state_nxt = enc_zero ? DONE : DIV;
            DIV:     if (cnt_q == '0)   state_nxt = DONE;
            DONE:    if (out_ready)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, divisor degree, and one long-division step per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q   <= '0;
            q_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            deg_q <= '0;
            cnt_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d_q   <= dividend;
                        b_q   <= divisor;
                        q_q   <= '0;
                        r_q   <= '0;
                        dbz_q <= 1'b0;
                    end
                end
                DEGREE: begin
                    deg_q <= enc_idx;
                    if (enc_zero) dbz_q <= 1'b1;
                    else          cnt_q <= CNT_W'(DIVIDEND_W - 1);
                end
                DIV: begin
                    r_q <= qb ? (t ^ b_q) : t;
                    q_q <= {q_q[DIVIDEND_W-2:0], qb};
                    d_q <= d_q << 1;
                    if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Results are only exposed in DONE so a partial quotient never reaches the outputs.
    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign quotient    = out_valid ? q_q : '0;
    assign remainder   = out_valid ? r_q : '0;
    assign div_by_zero = out_valid & dbz_q;

endmodule
